// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline MEM stage: accepts one load/store at a time,
// holds the pipeline for WAIT_STATES cycles, then returns a one-cycle response.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall_o
);
    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    funct3_q;
    logic          write_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, going_resp, commit, err, f3_ok, misalign, range_err;
    logic [31:0]   cur_addr, cur_wdata, rd_word, load_data, wr_lanes;
    logic [2:0]    cur_funct3;
    logic          cur_write;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [3:0]    be;

    assign accept  = req_valid && req_ready;
    assign stall_o = (req_valid && state == ST_IDLE) || state == ST_WAIT;

    // With zero wait states the response is formed on the accept edge itself, so the
    // decode works on the live request in IDLE and on the captured one otherwise.
    always_comb begin
        cur_addr   = (state == ST_IDLE) ? req_addr   : addr_q;
        cur_wdata  = (state == ST_IDLE) ? req_wdata  : wdata_q;
        cur_funct3 = (state == ST_IDLE) ? req_funct3 : funct3_q;
        cur_write  = (state == ST_IDLE) ? req_write  : write_q;

        lane      = cur_addr[1:0];
        idx       = cur_addr[AW+1:2];
        f3_ok     = cur_write ? (cur_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign  = (cur_funct3[1:0] == 2'b01 && cur_addr[0]) ||
                    (cur_funct3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00);
        range_err = {2'b00, cur_addr[31:2]} >= DEPTH_WORDS;
        err       = !f3_ok || misalign || range_err;

        rd_word = mem[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = 32'h0;
        endcase

        case (cur_funct3[1:0])
            2'b00:   begin be = 4'b0001 << lane; wr_lanes = {4{cur_wdata[7:0]}}; end
            2'b01:   begin be = cur_addr[1] ? 4'b1100 : 4'b0011; wr_lanes = {2{cur_wdata[15:0]}}; end
            default: begin be = 4'b1111; wr_lanes = cur_wdata; end
        endcase

        going_resp = reset && ((state == ST_IDLE && accept && WAIT_STATES == 0) ||
                               (state == ST_WAIT && cnt == CW'(LAST)));
        commit     = going_resp && cur_write && !err;
    end

    // NOTE: the storage array has no reset; clearing it would need a per-word reset
    // network, and software must not rely on its power-up contents anyway.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            funct3_q  <= 3'b000;
            write_q   <= 1'b0;
        end else begin
            if (going_resp) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= (err || cur_write) ? 32'h0 : load_data;
                rsp_err   <= err;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        funct3_q  <= req_funct3;
                        write_q   <= req_write;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (WAIT_STATES != 0) state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != CW'(LAST)) cnt <= cnt + CW'(1);
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait states (u0) and one
// with zero wait states (u1), sharing clock and reset.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic v0, w0, v1, w1;
    logic [31:0] a0, d0, a1, d1;
    logic [2:0] f0, f1;
    logic rdy0, rv0, er0, st0, rdy1, rv1, er1, st1;
    logic [31:0] rd0, rd1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0), .req_addr(a0),
        .req_wdata(d0), .req_funct3(f0), .req_ready(rdy0), .rsp_valid(rv0),
        .rsp_rdata(rd0), .rsp_err(er0), .stall_o(st0));

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_write(w1), .req_addr(a1),
        .req_wdata(d1), .req_funct3(f1), .req_ready(rdy1), .rsp_valid(rv1),
        .rsp_rdata(rd1), .rsp_err(er1), .stall_o(st1));

    // Issues one request on instance sel and returns the response and the cycle index
    // (request cycle = 0) at which rsp_valid was seen; stall_ok tracks stall_o shape.
    task automatic do_req(input int sel, input vec_t t, output logic [31:0] rdata,
                          output logic err, output int lat, output logic stall_ok);
        logic rv, st;
        @(negedge clk);
        if (sel == 0) begin v0 = 1; w0 = t.wr; a0 = t.addr; d0 = t.wdata; f0 = t.f3; end
        else          begin v1 = 1; w1 = t.wr; a1 = t.addr; d1 = t.wdata; f1 = t.f3; end
        #1;
        stall_ok = (sel == 0) ? (st0 && rdy0) : (st1 && rdy1);
        @(posedge clk);
        @(negedge clk);
        if (sel == 0) v0 = 0; else v1 = 0;
        lat = 1;
        rv = (sel == 0) ? rv0 : rv1;
        while (!rv && lat < 20) begin
            st = (sel == 0) ? st0 : st1;
            if (!st) stall_ok = 0;
            @(negedge clk);
            lat++;
            rv = (sel == 0) ? rv0 : rv1;
        end
        st = (sel == 0) ? st0 : st1;
        if (st) stall_ok = 0;
        rdata = (sel == 0) ? rd0 : rd1;
        err   = (sel == 0) ? er0 : er1;
        if (!rv) begin
            vectors++; miscompares++;
            $display("FAIL timeout addr=%h: no rsp_valid within 20 cycles", t.addr);
        end
    endtask

    task automatic run_table(input int sel, input string name, input vec_t t[], input int exp_lat);
        logic [31:0] rd;
        logic er, sok;
        int lat;
        foreach (t[i]) begin
            do_req(sel, t[i], rd, er, lat, sok);
            vectors += 4;
            if (rd !== t[i].exp) begin miscompares++;
                $display("FAIL %s[%0d] rdata got %h want %h", name, i, rd, t[i].exp); end
            if (er !== t[i].err) begin miscompares++;
                $display("FAIL %s[%0d] err got %b want %b", name, i, er, t[i].err); end
            if (lat != exp_lat) begin miscompares++;
                $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, exp_lat); end
            if (sok !== 1'b1) begin miscompares++;
                $display("FAIL %s[%0d] stall_o/req_ready shape got %b want 1", name, i, sok); end
        end
    endtask

    task automatic test_reset();
        reset = 0;
        v0 = 0; w0 = 0; a0 = 0; d0 = 0; f0 = 0;
        v1 = 0; w1 = 0; a1 = 0; d1 = 0; f1 = 0;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL reset req_ready got %b want 1", rdy0); end
        if (rv0 !== 1'b0) begin miscompares++; $display("FAIL reset rsp_valid got %b want 0", rv0); end
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL reset rsp_rdata got %h want 0", rd0); end
        if (er0 !== 1'b0) begin miscompares++; $display("FAIL reset rsp_err got %b want 0", er0); end
        if (st0 !== 1'b0) begin miscompares++; $display("FAIL reset stall_o got %b want 0", st0); end
        reset = 1;
    endtask

    task automatic test_word();
        vec_t t[] = new[2];
        t[0] = '{1'b1, 32'h10, 32'h8000_00F1, 3'b010, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_00F1, 1'b0};
        run_table(0, "word", t, 3);
    endtask

    task automatic test_subword();
        vec_t t[] = new[11];
        t[0]  = '{1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0};
        t[1]  = '{1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_0080, 1'b0};
        t[2]  = '{1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_8000, 1'b0};
        t[3]  = '{1'b0, 32'h10, 32'h0, 3'b101, 32'h0000_00F1, 1'b0};
        t[4]  = '{1'b1, 32'h11, 32'hFFFF_FFAB, 3'b000, 32'h0, 1'b0};
        t[5]  = '{1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_ABF1, 1'b0};
        t[6]  = '{1'b1, 32'h12, 32'h1234_BEEF, 3'b001, 32'h0, 1'b0};
        t[7]  = '{1'b0, 32'h10, 32'h0, 3'b010, 32'hBEEF_ABF1, 1'b0};
        t[8]  = '{1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_BEEF, 1'b0};
        t[9]  = '{1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_BEEF, 1'b0};
        t[10] = '{1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFF_FFF1, 1'b0};
        run_table(0, "subword", t, 3);
    endtask

    task automatic test_errors();
        vec_t t[] = new[10];
        t[0] = '{1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1};
        t[1] = '{1'b1, 32'h13, 32'h0000_5A5A, 3'b001, 32'h0, 1'b1};
        t[2] = '{1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1};
        t[3] = '{1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1};
        t[4] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 3'b100, 32'h0, 1'b1};
        t[5] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 3'b011, 32'h0, 1'b1};
        t[6] = '{1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1};
        t[7] = '{1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'h0, 1'b1};
        t[8] = '{1'b1, 32'h1010, 32'h1111_1111, 3'b010, 32'h0, 1'b1};
        t[9] = '{1'b0, 32'h10, 32'h0, 3'b010, 32'hBEEF_ABF1, 1'b0};
        run_table(0, "errors", t, 3);
    endtask

    task automatic test_zero_wait();
        vec_t t[] = new[2];
        t[0] = '{1'b1, 32'h0, 32'h0000_0042, 3'b010, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h0, 32'h0, 3'b010, 32'h0000_0042, 1'b0};
        run_table(1, "zero_wait", t, 1);
        // Held request: IDLE and RESP alternate, one accept every second cycle.
        @(negedge clk);
        v1 = 1; w1 = 0; a1 = 32'h0; f1 = 3'b010;
        for (int c = 0; c < 6; c++) begin
            #1;
            vectors += 2;
            if (rv1 !== logic'(c % 2)) begin miscompares++;
                $display("FAIL back_to_back c%0d rsp_valid got %b want %0d", c, rv1, c % 2); end
            if (rdy1 !== logic'(1 - c % 2)) begin miscompares++;
                $display("FAIL back_to_back c%0d req_ready got %b want %0d", c, rdy1, 1 - c % 2); end
            if (c % 2 == 1) begin
                vectors++;
                if (rd1 !== 32'h42) begin miscompares++;
                    $display("FAIL back_to_back c%0d rdata got %h want 00000042", c, rd1); end
            end
            @(negedge clk);
        end
        v1 = 0;
    endtask

    task automatic test_reset_mid_op();
        vec_t t[] = new[1];
        t[0] = '{1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0};
        run_table(0, "mid_pre", t, 3);
        @(negedge clk);
        v0 = 1; w0 = 1; a0 = 32'h20; d0 = 32'h1234_5678; f0 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        v0 = 0;
        vectors++;
        if (st0 !== 1'b1) begin miscompares++; $display("FAIL mid_op stall in WAIT got %b want 1", st0); end
        reset = 0;
        #1;
        vectors += 4;
        if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL mid_op req_ready got %b want 1", rdy0); end
        if (rv0 !== 1'b0) begin miscompares++; $display("FAIL mid_op rsp_valid got %b want 0", rv0); end
        if (st0 !== 1'b0) begin miscompares++; $display("FAIL mid_op stall_o got %b want 0", st0); end
        if (rd0 !== 32'h0) begin miscompares++; $display("FAIL mid_op rsp_rdata got %h want 0", rd0); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (rv0 !== 1'b0) begin miscompares++;
                $display("FAIL mid_op hold c%0d rsp_valid got %b want 0", c, rv0); end
        end
        reset = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (rv0 !== 1'b0) begin miscompares++;
                $display("FAIL mid_op after c%0d rsp_valid got %b want 0", c, rv0); end
        end
        t[0] = '{1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0};
        run_table(0, "mid_post", t, 3);
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_zero_wait();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
